// File: rtl/fc_pkg.sv
// Shared types and constants for the FC layer stream feeder.
package fc_pkg;
   localparam int FC_ADDR_W    = 12;
   localparam int FC_DATA_W    = 16;
   localparam int FC_FRAC_BITS = 10;
   localparam int FC_CNT_W     = 24;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND_IN = 3'd1,
      SEND_W  = 3'd2,
      SEND_B  = 3'd3,
      RECV    = 3'd4,
      FIN     = 3'd5
   } fc_state_t;
endpackage

// File: rtl/fc_stream_feeder_if.sv
// Stream handshake bundle between the feeder (master) and the FC core (slave).
interface fc_stream_feeder_if
   import fc_pkg::*;
   #(parameter int DATA_W = FC_DATA_W) ();

   logic              dout_valid;
   logic              dout_ready;
   logic [DATA_W-1:0] dout_data;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_data;

   modport master (output dout_valid, dout_data, res_ready,
                   input  dout_ready, res_valid, res_data);
   modport slave  (input  dout_valid, dout_data, res_ready,
                   output dout_ready, res_valid, res_data);
endinterface

// File: rtl/fc_skid_buf.sv
// Two-entry skid buffer fed by a 1-cycle-latency memory; grants read credits
// only when a slot is guaranteed, counting the read already in flight.
module fc_skid_buf
   import fc_pkg::*;
   #(parameter int DATA_W = FC_DATA_W) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue,
   input  logic              issue_zero,
   input  logic [DATA_W-1:0] rdata,
   output logic              slot_free,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic [1:0]        cnt;
   logic              infl;
   logic              infl_zero;
   logic [DATA_W-1:0] ent0;
   logic [DATA_W-1:0] ent1;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] push_data;
   logic [2:0]        occ;

   assign out_valid = (cnt != 2'd0);
   assign out_data  = ent0;
   assign pop       = out_valid && out_ready;
   assign push      = infl;
   assign push_data = infl_zero ? '0 : rdata;
   // a word leaving this cycle frees its slot for a read issued this cycle
   assign occ       = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
   assign slot_free = (occ < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 2'd0;
         infl      <= 1'b0;
         infl_zero <= 1'b0;
         ent0      <= '0;
         ent1      <= '0;
      end else begin
         infl      <= issue;
         infl_zero <= issue && issue_zero;
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) ent0 <= push_data;
               else             ent1 <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               ent0 <= ent1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  ent0 <= push_data;
               end else begin
                  ent0 <= ent1;
                  ent1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/fc_stream_feeder.sv
// Streams inputs, weights and biases of one FC layer to the core, then writes
// its results back. Optional stall counter: define FC_FEED_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for start
// SEND_IN | input activations transferring
// SEND_W  | weights transferring (cout rows of cin)
// SEND_B  | biases (or zeros) transferring
// RECV    | accepting cout results, writing to out_base+k
// FIN     | raise done, return to IDLE
module fc_stream_feeder
   import fc_pkg::*;
   #(parameter int ADDR_W = FC_ADDR_W,
     parameter int DATA_W = FC_DATA_W) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [11:0]          cin,
   input  logic [11:0]          cout,
   input  logic                 has_bias,
   input  logic [ADDR_W-1:0]    in_base,
   input  logic [ADDR_W-1:0]    w_base,
   input  logic [ADDR_W-1:0]    b_base,
   input  logic [ADDR_W-1:0]    out_base,
   output logic                 mem_ren,
   output logic [ADDR_W-1:0]    mem_raddr,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 mem_wen,
   output logic [ADDR_W-1:0]    mem_waddr,
   output logic [DATA_W-1:0]    mem_wdata,
   fc_stream_feeder_if.master   strm,
   output logic                 busy,
   output logic                 done
`ifdef FC_FEED_PERF_EN
   , output logic [31:0]        stall_cnt
`endif
);
   fc_state_t           state;
   fc_state_t           rd_state;
   logic [FC_CNT_W-1:0] xfer_left;
   logic [FC_CNT_W-1:0] rd_left;
   logic [FC_CNT_W-1:0] prod_r;
   logic [11:0]         cout_r;
   logic                has_bias_r;
   logic [ADDR_W-1:0]   w_base_r;
   logic [ADDR_W-1:0]   b_base_r;
   logic [ADDR_W-1:0]   rd_addr;
   logic [ADDR_W-1:0]   wr_addr;
   logic                start_ok;
   logic                start_go;
   logic                xfer;
   logic                acc;
   logic                slot_free;
   logic                issue;
   logic                issue_zero;

   assign start_ok   = start && (state == IDLE);
   assign start_go   = start_ok && (cin != 12'd0) && (cout != 12'd0);
   assign xfer       = strm.dout_valid && strm.dout_ready;
   assign acc        = (state == RECV) && strm.res_valid && strm.res_ready;
   assign issue      = (rd_state != IDLE) && slot_free;
   assign issue_zero = (rd_state == SEND_B) && !has_bias_r;

   assign mem_ren    = issue && !issue_zero;
   assign mem_raddr  = rd_addr;
   assign mem_wen    = acc;
   assign mem_waddr  = wr_addr;
   assign mem_wdata  = acc ? strm.res_data : '0;

   fc_skid_buf #(.DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .rst_n      (rst_n),
      .issue      (issue),
      .issue_zero (issue_zero),
      .rdata      (mem_rdata),
      .slot_free  (slot_free),
      .out_valid  (strm.dout_valid),
      .out_ready  (strm.dout_ready),
      .out_data   (strm.dout_data)
   );

   // Read sequencer runs ahead of the transfer FSM but strictly in stream
   // order, so phases overlap without any reordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state <= IDLE;
         rd_left  <= '0;
         rd_addr  <= '0;
      end else if (start_go) begin
         rd_state <= SEND_IN;
         rd_left  <= {12'd0, cin};
         rd_addr  <= in_base;
      end else if (issue) begin
         if (rd_left == 24'd1) begin
            case (rd_state)
               SEND_IN: begin
                  rd_state <= SEND_W;
                  rd_left  <= prod_r;
                  rd_addr  <= w_base_r;
               end
               SEND_W: begin
                  rd_state <= SEND_B;
                  rd_left  <= {12'd0, cout_r};
                  rd_addr  <= b_base_r;
               end
               default: begin
                  rd_state <= IDLE;
                  rd_left  <= '0;
               end
            endcase
         end else begin
            rd_left <= rd_left - 24'd1;
            rd_addr <= rd_addr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         xfer_left      <= '0;
         prod_r         <= '0;
         cout_r         <= '0;
         has_bias_r     <= 1'b0;
         w_base_r       <= '0;
         b_base_r       <= '0;
         wr_addr        <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         strm.res_ready <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  prod_r     <= 24'(cin) * 24'(cout);
                  cout_r     <= cout;
                  has_bias_r <= has_bias;
                  w_base_r   <= w_base;
                  b_base_r   <= b_base;
                  wr_addr    <= out_base;
                  xfer_left  <= {12'd0, cin};
                  busy       <= 1'b1;
                  state      <= ((cin == 12'd0) || (cout == 12'd0)) ? FIN : SEND_IN;
               end
            end
            SEND_IN: if (xfer) begin
               if (xfer_left == 24'd1) begin
                  state     <= SEND_W;
                  xfer_left <= prod_r;
               end else begin
                  xfer_left <= xfer_left - 24'd1;
               end
            end
            SEND_W: if (xfer) begin
               if (xfer_left == 24'd1) begin
                  state     <= SEND_B;
                  xfer_left <= {12'd0, cout_r};
               end else begin
                  xfer_left <= xfer_left - 24'd1;
               end
            end
            SEND_B: if (xfer) begin
               if (xfer_left == 24'd1) begin
                  state          <= RECV;
                  xfer_left      <= {12'd0, cout_r};
                  strm.res_ready <= 1'b1;
               end else begin
                  xfer_left <= xfer_left - 24'd1;
               end
            end
            RECV: if (acc) begin
               wr_addr <= wr_addr + 1'b1;
               if (xfer_left == 24'd1) begin
                  state          <= FIN;
                  strm.res_ready <= 1'b0;
               end else begin
                  xfer_left <= xfer_left - 24'd1;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FC_FEED_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (start_ok) begin
         stall_cnt <= '0;
      end else if ((((state == SEND_IN) || (state == SEND_W) || (state == SEND_B)) &&
                    strm.dout_valid && !strm.dout_ready) ||
                   ((state == RECV) && !strm.res_valid)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fc_stream_feeder.sv
// Randomized bench for fc_stream_feeder against a queue-based layer model.
module tb_fc_stream_feeder;
   import fc_pkg::*;
   localparam int AW = 12;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [11:0]   cin = '0;
   logic [11:0]   cout = '0;
   logic          has_bias = 1'b0;
   logic [AW-1:0] in_base = '0, w_base = '0, b_base = '0, out_base = '0;
   logic          mem_ren, mem_wen;
   logic [AW-1:0] mem_raddr, mem_waddr;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] mem_wdata;
   logic          busy, done;
`ifdef FC_FEED_PERF_EN
   logic [31:0]   stall_cnt;
`endif

   fc_stream_feeder_if #(.DATA_W(DW)) strm ();

   fc_stream_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cin       (cin),
      .cout      (cout),
      .has_bias  (has_bias),
      .in_base   (in_base),
      .w_base    (w_base),
      .b_base    (b_base),
      .out_base  (out_base),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .strm      (strm),
      .busy      (busy),
      .done      (done)
`ifdef FC_FEED_PERF_EN
      , .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:4095];
   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

   logic [DW-1:0] exp_s[$];
   logic [AW-1:0] exp_ra[$];
   logic [AW-1:0] exp_wa[$];
   logic [DW-1:0] exp_wd[$];
   logic [DW-1:0] res_q[$];
   int            n_chk = 0, n_err = 0;
   int            n_xfer = 0, first_cyc = 0, last_cyc = 0, cyc = 0;
   bit            rand_rdy = 0, rand_res = 0, res_acc = 0;
   bit            prev_stall = 0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
      end
   endtask

   // core / sink driver
   initial begin
      strm.dout_ready = 1'b1;
      strm.res_valid  = 1'b0;
      strm.res_data   = '0;
      forever begin
         @(posedge clk); #1;
         strm.dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (res_acc || !rst_n) begin
            strm.res_valid = 1'b0;
            res_acc = 0;
         end
         if (rst_n && !strm.res_valid && res_q.size() > 0 &&
             (!rand_res || $urandom_range(0, 1) == 1)) begin
            strm.res_valid = 1'b1;
            strm.res_data  = res_q[0];
         end
      end
   end

   // monitor
   initial begin
      bit acc;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            check("rw_excl", {31'd0, mem_ren && mem_wen}, 32'd0);
            if (prev_stall) begin
               check("hold_valid", strm.dout_valid, 1'b1);
               check("hold_data", strm.dout_data, prev_data);
            end
            if (strm.dout_valid && strm.dout_ready) begin
               if (exp_s.size() > 0) check("stream", strm.dout_data, exp_s.pop_front());
               else                  check("stream_extra", strm.dout_valid, 1'b0);
               n_xfer++;
               if (n_xfer == 1) first_cyc = cyc;
               last_cyc = cyc;
            end
            prev_stall = strm.dout_valid && !strm.dout_ready;
            prev_data  = strm.dout_data;
            if (mem_ren) begin
               if (exp_ra.size() > 0) check("raddr", mem_raddr, exp_ra.pop_front());
               else                   check("ren_spur", mem_ren, 1'b0);
            end
            acc = strm.res_valid && strm.res_ready;
            check("wen", mem_wen, acc);
            if (acc) begin
               if (exp_wa.size() > 0) begin
                  check("waddr", mem_waddr, exp_wa.pop_front());
                  check("wdata", mem_wdata, exp_wd.pop_front());
               end else begin
                  check("res_extra", strm.res_ready, 1'b0);
               end
               if (res_q.size() > 0) void'(res_q.pop_front());
               res_acc = 1;
            end
            if (strm.res_ready) check("rr_early", exp_s.size(), 32'd0);
         end else begin
            prev_stall = 0;
         end
      end
   end

   // builds the expected layer traffic, then pulses start with the config
   task automatic setup_layer(input int ci, input int co, input bit hb,
                              input logic [AW-1:0] ib, input logic [AW-1:0] wb,
                              input logic [AW-1:0] bb, input logic [AW-1:0] ob,
                              input bit fixed_res);
      logic [AW-1:0] a;
      logic [DW-1:0] r;
      if (ci != 0 && co != 0) begin
         for (int i = 0; i < ci; i++) begin
            a = ib + AW'(i); mem[a] = DW'($urandom);
            exp_s.push_back(mem[a]); exp_ra.push_back(a);
         end
         for (int i = 0; i < ci * co; i++) begin
            a = wb + AW'(i); mem[a] = DW'($urandom);
            exp_s.push_back(mem[a]); exp_ra.push_back(a);
         end
         for (int i = 0; i < co; i++) begin
            a = bb + AW'(i); mem[a] = DW'($urandom);
            if (hb) begin
               exp_s.push_back(mem[a]); exp_ra.push_back(a);
            end else begin
               exp_s.push_back('0);
            end
         end
         for (int k = 0; k < co; k++) begin
            r = fixed_res ? DW'((k + 1) << FC_FRAC_BITS) : DW'($urandom);
            res_q.push_back(r);
            exp_wa.push_back(ob + AW'(k));
            exp_wd.push_back(r);
         end
      end
      n_xfer = 0;
      @(posedge clk); #1;
      cin = 12'(ci); cout = 12'(co); has_bias = hb;
      in_base = ib; w_base = wb; b_base = bb; out_base = ob;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit got = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
      end
      check(tag, got, 1'b1);
      check("s_left", exp_s.size(), 32'd0);
      check("ra_left", exp_ra.size(), 32'd0);
      check("wr_left", exp_wa.size(), 32'd0);
      check("busy_end", busy, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ren", mem_ren, 1'b0);
      check("rst_wen", mem_wen, 1'b0);
      check("rst_dvalid", strm.dout_valid, 1'b0);
      check("rst_rready", strm.res_ready, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // basic layer with biases, fixed 1.0 / 2.0 results
      setup_layer(2, 2, 1, 12'h100, 12'h200, 12'h300, 12'h400, 1);
      wait_done("t1_done");
      check("t1_xfers", n_xfer, 32'd8);
      check("t1_burst", last_cyc - first_cyc, 32'd7);

      // no bias: zeros streamed, no bias-range reads
      setup_layer(2, 2, 0, 12'h110, 12'h210, 12'h310, 12'h410, 0);
      wait_done("t2_done");
      check("t2_xfers", n_xfer, 32'd8);

      // random backpressure on both sides, wrapping weight range
      rand_rdy = 1; rand_res = 1;
      setup_layer(5, 3, 1, 12'h120, 12'hFF8, 12'h320, 12'h420, 0);
      wait_done("t3_done");
      check("t3_xfers", n_xfer, 32'd23);

      // zero input channels: straight to FIN
      rand_rdy = 0; rand_res = 0;
      setup_layer(0, 4, 1, 12'h130, 12'h230, 12'h330, 12'h430, 0);
      @(negedge clk);
      check("z_busy1", busy, 1'b1);
      check("z_done1", done, 1'b0);
      @(negedge clk);
      check("z_busy2", busy, 1'b0);
      check("z_done2", done, 1'b1);
      @(negedge clk);
      check("z_done3", done, 1'b0);

      // async reset during weights
      setup_layer(4, 4, 1, 12'h140, 12'h240, 12'h340, 12'h440, 0);
      for (int i = 0; i < 2000 && n_xfer < 6; i++) @(negedge clk);
      check("t5_reach", n_xfer >= 6, 1'b1);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("ar_busy", busy, 1'b0);
      check("ar_done", done, 1'b0);
      check("ar_ren", mem_ren, 1'b0);
      check("ar_raddr", mem_raddr, 32'd0);
      check("ar_wen", mem_wen, 1'b0);
      check("ar_waddr", mem_waddr, 32'd0);
      check("ar_wdata", mem_wdata, 32'd0);
      check("ar_dvalid", strm.dout_valid, 1'b0);
      check("ar_ddata", strm.dout_data, 32'd0);
      check("ar_rready", strm.res_ready, 1'b0);
      exp_s.delete(); exp_ra.delete(); exp_wa.delete(); exp_wd.delete(); res_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      setup_layer(3, 2, 1, 12'h150, 12'h250, 12'h350, 12'h450, 0);
      wait_done("t5_done");
      check("t5_xfers", n_xfer, 32'd11);

      // start re-pulsed during RECV with a different out_base
      rand_res = 1;
      setup_layer(3, 3, 1, 12'h160, 12'h260, 12'h360, 12'h500, 0);
      got = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (strm.res_ready) begin got = 1; break; end
      end
      check("t6_recv", got, 1'b1);
      @(posedge clk); #1;
      out_base = 12'h7F0; cin = 12'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("t6_done");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
